// File: rtl/mux_scan_ctrl_if.sv
// Handshake and select bundle between a scan requester, the scan sequencer and the 8:1 mux.
// The master side requests scans and provides the mux output; the slave side is the sequencer.
interface mux_scan_ctrl_if;
  logic       start;
  logic [7:0] chan_mask;
  logic       mux_out;
  logic       S0;
  logic       S1;
  logic       S2;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [3:0] hit_count;

  modport master (
    output start, chan_mask, mux_out,
    input  S0, S1, S2, busy, done, result, hit_count
  );

  modport slave (
    input  start, chan_mask, mux_out,
    output S0, S1, S2, busy, done, result, hit_count
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: walks the enabled channels in ascending order, holds each
// select for SETTLE+1 cycles and captures mux_out into a per-channel result bit.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input logic            clk,
  input logic            rst,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam int unsigned SettleM1   = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [3:0]  SettleLast = SettleM1[3:0];
  // With no settle time each channel goes straight to its sample cycle.
  localparam logic [1:0]  StFirst    = (SETTLE == 0) ? StSample : StSettle;

  logic [1:0] state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] result_q, result_d;
  logic [3:0] hit_q, hit_d;

  logic [7:0] pe_in;
  logic [2:0] low_ch;
  logic       low_any;

  // In IDLE look at the incoming mask; otherwise at the channels still left after this one.
  always_comb begin
    pe_in   = (state_q == StIdle) ? bus.chan_mask : (mask_q & ~(8'd1 << sel_q));
    low_ch  = 3'd0;
    low_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (pe_in[i]) begin
        low_ch  = 3'(i);
        low_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    hit_d    = hit_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          mask_d   = bus.chan_mask;
          result_d = 8'd0;
          hit_d    = 4'd0;
          busy_d   = 1'b1;
          cnt_d    = 4'd0;
          if (low_any) begin
            sel_d   = low_ch;
            state_d = StFirst;
          end else begin
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = 4'd0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        result_d[sel_q] = bus.mux_out;
        if (bus.mux_out) begin
          hit_d = hit_q + 4'd1;
        end
        mask_d = pe_in;
        cnt_d  = 4'd0;
        if (low_any) begin
          sel_d   = low_ch;
          state_d = StFirst;
        end else begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= 3'd0;
      mask_q   <= 8'd0;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 8'd0;
      hit_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      hit_q    <= hit_d;
    end
  end

  assign bus.S0        = sel_q[0];
  assign bus.S1        = sel_q[1];
  assign bus.S2        = sel_q[2];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.hit_count = hit_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with SETTLE=1 and one with SETTLE=0, each driving a
// behavioural 8:1 mux; table-driven scans plus reset, busy-protection and mid-scan-reset cases.
module tb_mux_scan_ctrl;

  typedef struct {
    bit         which;
    logic [7:0] mask;
    logic [7:0] data;
    logic [7:0] res;
    int         hit;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] result;
    int         hit;
    int         lat;
  } scan_exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] d0;
  logic [7:0] d1;
  int         n_vec;
  int         n_err;
  logic [2:0] exp_sel [2];
  scan_exp_t  sb[$];
  vec_t       vecs[8];

  mux_scan_ctrl_if if0 ();
  mux_scan_ctrl_if if1 ();

  mux_scan_ctrl #(.SETTLE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  mux_scan_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if0.mux_out = d0[{if0.S2, if0.S1, if0.S0}];
  assign if1.mux_out = d1[{if1.S2, if1.S1, if1.S0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] get_sel(input bit w);
    return w ? {if1.S2, if1.S1, if1.S0} : {if0.S2, if0.S1, if0.S0};
  endfunction
  function automatic logic get_done(input bit w);
    return w ? if1.done : if0.done;
  endfunction
  function automatic logic get_busy(input bit w);
    return w ? if1.busy : if0.busy;
  endfunction
  function automatic logic [7:0] get_res(input bit w);
    return w ? if1.result : if0.result;
  endfunction
  function automatic logic [3:0] get_hit(input bit w);
    return w ? if1.hit_count : if0.hit_count;
  endfunction
  function automatic logic all_zero(input bit w);
    return get_sel(w) == 3'd0 && !get_busy(w) && !get_done(w) && get_res(w) == 8'd0 &&
           get_hit(w) == 4'd0;
  endfunction

  task automatic drive(input bit w, input logic s, input logic [7:0] m, input logic [7:0] d);
    if (w) begin
      if1.start = s; if1.chan_mask = m; d1 = d;
    end else begin
      if0.start = s; if0.chan_mask = m; d0 = d;
    end
  endtask

  task automatic set_start(input bit w, input logic s);
    if (w) if1.start = s;
    else if0.start = s;
  endtask

  task automatic run_scan(input bit w, input logic [7:0] mask, input logic [7:0] data,
                          input logic [7:0] exp_res, input int exp_hit, input int exp_lat,
                          input int repulse);
    scan_exp_t  e;
    scan_exp_t  got;
    logic [2:0] trace[$];
    logic [2:0] exp_trace[$];
    int         st;
    int         k;
    int         busy_bad;
    int         trace_bad;
    bit         seen;
    logic [2:0] last_sel;
    st = w ? 1 : 0;
    e.result = exp_res;
    e.hit    = exp_hit;
    e.lat    = exp_lat;
    sb.push_back(e);
    for (int ch = 0; ch < 8; ch++)
      if (mask[ch]) for (int r = 0; r <= st; r++) exp_trace.push_back(3'(ch));
    last_sel = exp_sel[w];
    for (int ch = 0; ch < 8; ch++) if (mask[ch]) last_sel = 3'(ch);

    drive(w, 1'b1, mask, data);
    tick();
    // mask changes after accept must not affect the running scan
    drive(w, 1'b0, ~mask, data);
    if (exp_lat > 0) cmp("accept_clear", {get_res(w), get_hit(w)}, 0);
    k = 0;
    seen = 1'b0;
    busy_bad = 0;
    while (!seen && k < 200) begin
      if (!get_busy(w)) busy_bad++;
      if (get_done(w)) begin
        seen = 1'b1;
      end else begin
        trace.push_back(get_sel(w));
        set_start(w, repulse > 0 && k == repulse - 1);
        tick();
        set_start(w, 1'b0);
        k++;
      end
    end
    if (!seen) begin
      cmp("done_timeout", 0, 1);
      void'(sb.pop_front());
      return;
    end
    got = sb.pop_front();
    cmp("result", get_res(w), got.result);
    cmp("hit_count", get_hit(w), got.hit);
    cmp("latency", k, got.lat);
    cmp("busy_during_scan", busy_bad, 0);
    trace_bad = (trace.size() != exp_trace.size()) ? 1 : 0;
    if (trace_bad == 0)
      foreach (trace[i]) if (trace[i] != exp_trace[i]) trace_bad++;
    cmp("sel_trace", trace_bad, 0);
    cmp("sel_final", get_sel(w), last_sel);
    exp_sel[w] = last_sel;
    tick();
    cmp("post_done", {get_done(w), get_busy(w), get_res(w), get_hit(w), get_sel(w)},
        {1'b0, 1'b0, exp_res, 4'(exp_hit), last_sel});
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{1'b1, 8'hFF, 8'hB2, 8'hB2, 4, 16};
    vecs[1] = '{1'b0, 8'hA1, 8'hFF, 8'hA1, 3, 3};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 0, 0};
    vecs[3] = '{1'b1, 8'h80, 8'h80, 8'h80, 1, 2};
    vecs[4] = '{1'b0, 8'h3C, 8'h55, 8'h14, 2, 4};
    vecs[5] = '{1'b1, 8'h01, 8'h00, 8'h00, 0, 2};
    vecs[6] = '{1'b0, 8'hFF, 8'h6A, 8'h6A, 4, 8};
    vecs[7] = '{1'b0, 8'h00, 8'hFF, 8'h00, 0, 0};

    // Reset held two cycles with start high on both instances.
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    drive(1'b1, 1'b1, 8'hFF, 8'hFF);
    tick();
    cmp("reset_c1_dut0", all_zero(1'b0), 1);
    cmp("reset_c1_dut1", all_zero(1'b1), 1);
    tick();
    cmp("reset_c2_dut0", all_zero(1'b0), 1);
    cmp("reset_c2_dut1", all_zero(1'b1), 1);
    rst = 1'b0;
    set_start(1'b0, 1'b0);
    set_start(1'b1, 1'b0);
    tick();
    cmp("idle_after_reset", {get_busy(1'b0), get_busy(1'b1)}, 0);
    exp_sel[0] = 3'd0;
    exp_sel[1] = 3'd0;

    foreach (vecs[i])
      run_scan(vecs[i].which, vecs[i].mask, vecs[i].data, vecs[i].res, vecs[i].hit,
               vecs[i].lat, 0);

    // Busy protection: start pulsed again at edge +5 must be ignored.
    run_scan(1'b1, 8'hFF, 8'hB2, 8'hB2, 4, 16, 5);
    begin
      int bad;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
        if (get_busy(1'b1) || get_done(1'b1)) bad++;
        tick();
      end
      cmp("no_second_scan", bad, 0);
    end

    // Mid-scan reset: rst seen at edge +7 aborts with no done pulse.
    begin
      int done_seen;
      done_seen = 0;
      drive(1'b1, 1'b1, 8'hFF, 8'hB2);
      tick();
      set_start(1'b1, 1'b0);
      for (int c = 0; c < 6; c++) begin
        if (get_done(1'b1)) done_seen++;
        tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cmp("midscan_reset_zero", all_zero(1'b1), 1);
      for (int c = 0; c < 20; c++) begin
        if (get_done(1'b1) || get_busy(1'b1)) done_seen++;
        tick();
      end
      cmp("midscan_no_done", done_seen, 0);
      exp_sel[0] = 3'd0;
      exp_sel[1] = 3'd0;
    end
    run_scan(1'b1, 8'h5A, 8'hF0, 8'h50, 2, 8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
